// File: rtl/mem_be_sync_ram.sv
// mem_be_sync_ram: byte-lane single-port RAM with request handshake, pipelined valid-qualified reads and self-clearing init
//   clk, rst                 : rising-edge clock, async active-high reset
//   req_valid/req_ready      : request handshake; ready only once the init sweep is complete
//   req_we, req_be, req_addr, req_wd : write flag, byte-lane enables, word address, write data
//   rsp_valid, rsp_rd, rsp_err : one-cycle read pulse, read data, out-of-range flag (data/err hold between pulses)
//   init_done                : clear sweep finished
module mem_be_sync_ram #(
    parameter int WIDTH    = 24,
    parameter int AMOUNT   = 64,
    parameter int READ_LAT = 1,
    parameter int AW       = $clog2(AMOUNT),
    parameter int LANES    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [LANES-1:0] req_be,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wd,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rd,
    output logic             rsp_err,
    output logic             init_done
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] mem [AMOUNT];
    logic acc, rd_acc, in_range, last;
    logic rv1_q, err1_q;
    logic [WIDTH-1:0] rd1_q;
    assign req_ready = state_q == RUN;
    assign init_done = state_q == RUN;
    assign acc       = req_valid & req_ready;
    assign rd_acc    = acc & ~req_we;
    assign in_range  = 32'(req_addr) < AMOUNT;
    assign last      = 32'(ptr_q) == AMOUNT - 1;
    always_comb begin
        state_d = (state_q == INIT && last) ? RUN : state_q;
        ptr_d   = (state_q == INIT) ? ptr_q + 1'b1 : ptr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end
    // No reset on the array so it maps onto RAM; the init sweep defines its contents.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            mem[ptr_q] <= '0;
        else if (acc && req_we && in_range)
            for (int i = 0; i < LANES; i++)
                if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wd[8*i +: 8];
    end
    // Read samples pre-write contents, so a same-cycle or later write never leaks into this response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv1_q  <= 1'b0;
            rd1_q  <= '0;
            err1_q <= 1'b0;
        end else begin
            rv1_q <= rd_acc;
            if (rd_acc) begin
                rd1_q  <= in_range ? mem[req_addr] : '0;
                err1_q <= ~in_range;
            end
        end
    end
    if (READ_LAT == 2) begin : g_lat2
        logic rv2_q, err2_q;
        logic [WIDTH-1:0] rd2_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rv2_q  <= 1'b0;
                rd2_q  <= '0;
                err2_q <= 1'b0;
            end else begin
                rv2_q <= rv1_q;
                if (rv1_q) begin
                    rd2_q  <= rd1_q;
                    err2_q <= err1_q;
                end
            end
        end
        assign rsp_valid = rv2_q;
        assign rsp_rd    = rd2_q;
        assign rsp_err   = err2_q;
    end else begin : g_lat1
        assign rsp_valid = rv1_q;
        assign rsp_rd    = rd1_q;
        assign rsp_err   = err1_q;
    end
endmodule

// File: tb/tb_mem_be_sync_ram.sv
// tb_mem_be_sync_ram: directed bench for mem_be_sync_ram (default, READ_LAT=2 and AMOUNT=48 instances share stimulus)
module tb_mem_be_sync_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [2:0] req_be = '0;
    logic [5:0] req_addr = '0;
    logic [23:0] req_wd = '0;
    logic [2:0] rdy, rv, er, idn;
    logic [23:0] rd [3];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_be_sync_ram dut0 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wd(req_wd), .rsp_valid(rv[0]), .rsp_rd(rd[0]),
        .rsp_err(er[0]), .init_done(idn[0]));
    mem_be_sync_ram #(.READ_LAT(2)) dut2 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wd(req_wd), .rsp_valid(rv[1]),
        .rsp_rd(rd[1]), .rsp_err(er[1]), .init_done(idn[1]));
    mem_be_sync_ram #(.AMOUNT(48)) dut48 (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wd(req_wd), .rsp_valid(rv[2]),
        .rsp_rd(rd[2]), .rsp_err(er[2]), .init_done(idn[2]));

    task automatic drive(input logic v, input logic we, input logic [2:0] be, input logic [5:0] a, input logic [23:0] d);
        req_valid = v; req_we = we; req_be = be; req_addr = a; req_wd = d;
    endtask

    task automatic wr(input logic [5:0] a, input logic [2:0] be, input logic [23:0] d);
        @(negedge clk); drive(1, 1, be, a, d);
    endtask

    // Returns at the negedge after the accept edge, where a READ_LAT=1 response is visible.
    task automatic rd1(input logic [5:0] a);
        @(negedge clk); drive(1, 0, 0, a, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
    endtask

    // Call at the negedge where rst is released.
    task automatic wait_init;
        int n = 0, m = 0;
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            if (rdy[0] | idn[0] | rdy[1]) n++;
            if (rdy[2] !== (i >= 48)) m++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL init_ready_early: got %0d early cycles, want 0", n); end
        checks++; if (m !== 0) begin failures++; $display("FAIL init48_ready: got %0d wrong cycles, want 0", m); end
        @(negedge clk); drive(0, 0, 0, 0, 0);
        checks++; if ({rdy[0], idn[0]} !== 2'b11) begin failures++; $display("FAIL init_done: got %b want 11", {rdy[0], idn[0]}); end
    endtask

    task automatic test_reset;
        drive(1, 1, 3'b111, 3, 24'h123456);
        @(negedge clk);
        checks++;
        if ({rdy[0], rv[0], er[0], idn[0], rd[0]} !== 28'h0) begin
            failures++; $display("FAIL reset_state: got %h want 0", {rdy[0], rv[0], er[0], idn[0], rd[0]});
        end
        rst = 1'b0;
    endtask

    task automatic test_init;
        int a [4] = '{0, 31, 63, 3};
        wait_init();
        for (int k = 0; k < 4; k++) begin
            rd1(6'(a[k]));
            checks++;
            if ({rv[0], er[0], rd[0]} !== {1'b1, 1'b0, 24'h0}) begin
                failures++; $display("FAIL init_read addr %0d: got v=%b e=%b d=%h want v=1 e=0 d=000000", a[k], rv[0], er[0], rd[0]);
            end
        end
    endtask

    task automatic test_byte_enables;
        wr(5, 3'b111, 24'hAABBCC);
        wr(5, 3'b010, 24'h112233);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        checks++; if (rv[0] !== 1'b0) begin failures++; $display("FAIL write_no_rsp: got %b want 0", rv[0]); end
        rd1(5);
        checks++;
        if ({rv[0], rd[0]} !== {1'b1, 24'hAA22CC}) begin failures++; $display("FAIL be_merge: got v=%b d=%h want v=1 d=aa22cc", rv[0], rd[0]); end
        wr(5, 3'b000, 24'hFFFFFF);
        rd1(5);
        checks++;
        if ({rv[0], rd[0]} !== {1'b1, 24'hAA22CC}) begin failures++; $display("FAIL be_zero: got v=%b d=%h want v=1 d=aa22cc", rv[0], rd[0]); end
    endtask

    task automatic test_ordering;
        wr(7, 3'b111, 24'h000001);
        rd1(7);
        checks++;
        if ({rv[0], rd[0]} !== {1'b1, 24'h000001}) begin failures++; $display("FAIL raw_next: got v=%b d=%h want v=1 d=000001", rv[0], rd[0]); end
        @(negedge clk); drive(1, 0, 0, 7, 0);
        @(negedge clk);
        checks++;
        if ({rv[0], rd[0]} !== {1'b1, 24'h000001}) begin failures++; $display("FAIL war_old: got v=%b d=%h want v=1 d=000001", rv[0], rd[0]); end
        drive(1, 1, 3'b111, 7, 24'h000002);
        rd1(7);
        checks++;
        if ({rv[0], rd[0]} !== {1'b1, 24'h000002}) begin failures++; $display("FAIL war_new: got v=%b d=%h want v=1 d=000002", rv[0], rd[0]); end
    endtask

    task automatic test_back_to_back;
        logic v1, v2;
        logic [7:0] b1, b2;
        wr(1, 3'b111, 24'h010101);
        wr(2, 3'b111, 24'h020202);
        wr(3, 3'b111, 24'h030303);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            v1 = (k >= 1 && k <= 3);
            v2 = (k >= 2 && k <= 4);
            b1 = 8'(k > 3 ? 3 : k);
            b2 = 8'(k > 4 ? 3 : k - 1);
            checks++; if (rv[0] !== v1) begin failures++; $display("FAIL b2b_v1 step %0d: got %b want %b", k, rv[0], v1); end
            checks++; if (rv[1] !== v2) begin failures++; $display("FAIL b2b_v2 step %0d: got %b want %b", k, rv[1], v2); end
            if (k >= 1) begin
                checks++; if (rd[0] !== {3{b1}}) begin failures++; $display("FAIL b2b_d1 step %0d: got %h want %h", k, rd[0], {3{b1}}); end
            end
            if (k >= 2) begin
                checks++; if (rd[1] !== {3{b2}}) begin failures++; $display("FAIL b2b_d2 step %0d: got %h want %h", k, rd[1], {3{b2}}); end
            end
            if (k < 3) drive(1, 0, 0, 6'(k + 1), 0);
            else drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_out_of_range;
        wr(50, 3'b111, 24'hFFFFFF);
        @(negedge clk); drive(1, 0, 0, 2, 0);
        @(negedge clk);
        checks++;
        if ({rv[2], er[2], rd[2]} !== {1'b1, 1'b0, 24'h020202}) begin failures++; $display("FAIL oor_pre: got v=%b e=%b d=%h want 1 0 020202", rv[2], er[2], rd[2]); end
        drive(1, 0, 0, 50, 0);
        @(negedge clk);
        checks++;
        if ({rv[2], er[2], rd[2]} !== {1'b1, 1'b1, 24'h0}) begin failures++; $display("FAIL oor_read: got v=%b e=%b d=%h want 1 1 000000", rv[2], er[2], rd[2]); end
        checks++;
        if ({rv[0], er[0], rd[0]} !== {1'b1, 1'b0, 24'hFFFFFF}) begin failures++; $display("FAIL inrange_50: got v=%b e=%b d=%h want 1 0 ffffff", rv[0], er[0], rd[0]); end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({rv[2], er[2], rd[2]} !== {1'b0, 1'b1, 24'h0}) begin failures++; $display("FAIL oor_hold: got v=%b e=%b d=%h want 0 1 000000", rv[2], er[2], rd[2]); end
        drive(1, 0, 0, 47, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        checks++;
        if ({rv[2], er[2], rd[2]} !== {1'b1, 1'b0, 24'h0}) begin failures++; $display("FAIL oor_last: got v=%b e=%b d=%h want 1 0 000000", rv[2], er[2], rd[2]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); drive(1, 0, 0, 5, 0);
        @(posedge clk); #1 rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({rv[0], rv[1], rdy[0], idn[0], rd[0]} !== 28'h0) begin
            failures++; $display("FAIL mid_reset_state: got %h want 0", {rv[0], rv[1], rdy[0], idn[0], rd[0]});
        end
        @(negedge clk);
        checks++; if (rv[1:0] !== 2'b00) begin failures++; $display("FAIL flush_1: got %b want 00", rv[1:0]); end
        @(negedge clk);
        checks++; if (rv[1:0] !== 2'b00) begin failures++; $display("FAIL flush_2: got %b want 00", rv[1:0]); end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_init();
        rd1(5);
        checks++;
        if ({rv[0], er[0], rd[0]} !== {1'b1, 1'b0, 24'h0}) begin failures++; $display("FAIL reinit_5: got v=%b e=%b d=%h want 1 0 000000", rv[0], er[0], rd[0]); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_enables();
        test_ordering();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_be_sync_ram.md
Name: mem_be_sync_ram

Overview:
- Parametrised successor to the project's single-port word memory, for the processor's instruction and data stores.
- Adds the following over the earlier block:
  - per-byte-lane write enables;
  - registered, pipelined read with a valid-qualified response;
  - a request handshake;
  - address range checking;
  - a self-clearing init sequence after reset, so memory contents are defined without a preload file.

Parameters:
- WIDTH, 24, data word width in bits; must be a multiple of 8.
- AMOUNT, 64, number of words; need not be a power of two.
- READ_LAT, 1, read latency in cycles from accept to rsp_valid; legal values 1 or 2.
- AW, $clog2(AMOUNT), address width (derived; not overridden).
- LANES, WIDTH/8, number of byte lanes (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  LANES  byte-lane write enables; bit i covers wd[8i+7:8i].
- req_addr  in  AW  word address.
- req_wd  in  WIDTH  write data.
- rsp_valid  out  1  read response valid (one-cycle pulse per read).
- rsp_rd  out  WIDTH  read data.
- rsp_err  out  1  response address was out of range (qualified by rsp_valid).
- init_done  out  1  init sweep complete.

Behaviour:
- Reset (async, asserts immediately): req_ready=0, rsp_valid=0, rsp_rd=0, rsp_err=0, init_done=0.
  - Read pipeline is flushed.
  - FSM enters INIT with init pointer = 0.
- FSM states: INIT and RUN.
  - INIT: one word written to all-zeros per cycle, pointer 0..AMOUNT-1. Takes exactly AMOUNT cycles after rst deasserts.
  - INIT to RUN on the cycle the pointer writes AMOUNT-1.
  - In RUN, init_done=1 and req_ready=1 permanently.
  - No path from RUN back to INIT except rst.
- req_ready is 0 throughout INIT; requests presented then are not accepted and have no effect.
- Accept: a request is accepted when req_valid & req_ready is high at the clk edge. Maximum one request per cycle, no back-pressure in RUN.
- Write (accepted, req_we=1):
  - Lane i of word req_addr is updated iff req_be[i]=1; other lanes keep their old value.
  - req_be = 0 means no change.
  - A write generates no response.
- Read (accepted, req_we=0):
  - READ_LAT=1: rsp_valid=1 on the next cycle, with rsp_rd = word contents.
  - READ_LAT=2: an extra output register is added; the response arrives 2 cycles after accept.
  - Reads are fully pipelined: back-to-back reads give back-to-back responses, in order.
- Ordering: a write accepted in cycle N is visible to a read accepted in cycle N+1 or later. A read always returns memory state before any write accepted in the same or a later cycle.
- Range check (req_addr >= AMOUNT):
  - Write: ignored, memory unchanged.
  - Read: response still produced at normal latency, with rsp_rd=0 and rsp_err=1.
  - In-range reads give rsp_err=0.
- rsp_rd and rsp_err hold their last value when rsp_valid=0. Only rsp_valid is a pulse.
- Reset mid-operation:
  - In-flight read responses are discarded; rsp_valid stays 0.
  - Memory is re-cleared by a fresh INIT sweep.
  - Writes accepted before rst are lost after the sweep.
- Mid-INIT reset: the sweep restarts from address 0.
- Storage: memory array has no reset term (RAM-inferable). Only the control/pipeline registers use the async reset.

Test Plan:
- Init: release rst, AMOUNT=64 → req_ready=0 for 64 cycles, then init_done=req_ready=1; reads of addr 0, 31, 63 return 0x000000 with rsp_err=0.
- Byte enables: write 0xAABBCC to addr 5 with be=3'b111, then 0x112233 with be=3'b010, read addr 5 → rsp_rd=0xAA22CC one cycle after accept (READ_LAT=1).
- Pipelining and ordering:
  - Write 0x000001 to addr 7 in cycle N; read addr 7 in N+1 → 0x000001.
  - Reads of addr 1, 2, 3 in consecutive cycles → three consecutive rsp_valid pulses in order.
  - Repeat with READ_LAT=2 → each response arrives 2 cycles after accept.
- Out of range (AMOUNT=48, AW=6):
  - Write 0xFFFFFF to addr 50 → no memory change.
  - Read addr 50 → rsp_valid=1, rsp_err=1, rsp_rd=0.
  - Read addr 47 → rsp_err=0.
- Reset mid-operation:
  - Issue a read, assert rst in the accept cycle → rsp_valid never pulses.
  - After the new 64-cycle INIT, the previously written addr 5 reads 0x000000.
- INIT-phase requests: hold req_valid=1, req_we=1, addr 3, wd 0x123456 during INIT → not accepted; addr 3 reads 0 after init_done.
